// File: rtl/parking_sensor_emulator.sv
// parking_sensor_emulator: drives the two-beam (a,b) gate sensor
// through one car entering or exiting, with per-phase dwell and back-out.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   enter_req, exit_req   level requests for one enter / exit sequence
//   abort                 level; backs out the sequence while in P1..P3
//   dwell_cycles [DW]     cycles per phase, latched on accept, 0 -> 1
//   a, b                  registered beam outputs, 1 = blocked
//   busy                  sequence in progress
//   ack, done, aborted    single-cycle event pulses
//   enter_count, exit_count [CNT_W]  completed sequences, wrapping
module parking_sensor_emulator #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enter_req,
  input  logic             exit_req,
  input  logic             abort,
  input  logic [DW-1:0]    dwell_cycles,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             ack,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] enter_count,
  output logic [CNT_W-1:0] exit_count
);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    P2,
    P3,
    GAP,
    BK2,
    BK1,
    BKGAP
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [DW-1:0] cnt;
  logic [DW-1:0] last;
  logic          dir;
  logic          dir_n;
  logic          accept;
  logic          expire;
  logic [1:0]    ph;
  logic          a_n;
  logic          b_n;
  logic          busy_n;
  logic          done_n;
  logic          abt_n;

  // enter wins when both requests are high
  assign accept = (state == IDLE)
                & (enter_req | exit_req);
  assign dir_n  = accept ? ~enter_req : dir;

  // last is D-1, so a phase lasts cnt = 0 .. D-1
  assign expire = (cnt == last);

  // state register, dwell counter and latched request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= '0;
      dir   <= 1'b0;
    end else begin
      state <= nxt;
      dir   <= dir_n;
      if (accept) begin
        if (dwell_cycles == '0)
          last <= '0;
        else
          last <= dwell_cycles - 1'b1;
      end
      if (nxt != state || nxt == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  // next state; abort beats dwell expiry
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept)
          nxt = P1;
      end
      P1: begin
        if (abort)
          nxt = BKGAP;
        else if (expire)
          nxt = P2;
      end
      P2: begin
        if (abort)
          nxt = BK1;
        else if (expire)
          nxt = P3;
      end
      P3: begin
        if (abort)
          nxt = BK2;
        else if (expire)
          nxt = GAP;
      end
      GAP: begin
        if (expire)
          nxt = IDLE;
      end
      BK2: begin
        if (expire)
          nxt = BK1;
      end
      BK1: begin
        if (expire)
          nxt = BKGAP;
      end
      BKGAP: begin
        if (expire)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // next outputs; phases are for enter and
  // swapped (a<->b) for exit
  always_comb begin
    ph = 2'b00;
    unique case (nxt)
      P1, BK1: ph = 2'b10;
      P2, BK2: ph = 2'b11;
      P3:      ph = 2'b01;
      default: ph = 2'b00;
    endcase
    if (dir_n) begin
      a_n = ph[0];
      b_n = ph[1];
    end else begin
      a_n = ph[1];
      b_n = ph[0];
    end
    busy_n = (nxt != IDLE);
    done_n = (state == GAP) & expire;
    abt_n  = (state == BKGAP) & expire;
  end

  // registered outputs and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a           <= 1'b0;
      b           <= 1'b0;
      busy        <= 1'b0;
      ack         <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      enter_count <= '0;
      exit_count  <= '0;
    end else begin
      a       <= a_n;
      b       <= b_n;
      busy    <= busy_n;
      ack     <= accept;
      done    <= done_n;
      aborted <= abt_n;
      if (done_n && !dir)
        enter_count <= enter_count + 1'b1;
      if (done_n && dir)
        exit_count <= exit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parking_sensor_emulator.sv
// tb_parking_sensor_emulator: vector tables, reset and wrap
// sequences, and random traffic against a phase-list model.
module tb_parking_sensor_emulator;

  logic        clk;
  logic        reset_n;
  logic        enter_req;
  logic        exit_req;
  logic        abort;
  logic [7:0]  dwell_cycles;
  logic        a, b, busy, ack, done, aborted;
  logic [15:0] enter_count, exit_count;

  logic        w_en;
  logic        w_a, w_b, w_busy, w_ack, w_done, w_abt;
  logic [3:0]  w_ec, w_xc;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  parking_sensor_emulator #(.DW(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .enter_req(enter_req), .exit_req(exit_req),
    .abort(abort), .dwell_cycles(dwell_cycles),
    .a(a), .b(b), .busy(busy), .ack(ack),
    .done(done), .aborted(aborted),
    .enter_count(enter_count), .exit_count(exit_count)
  );

  // narrow counters so wrap is reachable quickly
  parking_sensor_emulator #(.DW(8), .CNT_W(4)) dutw (
    .clk(clk), .reset_n(reset_n),
    .enter_req(w_en), .exit_req(1'b0),
    .abort(1'b0), .dwell_cycles(8'd0),
    .a(w_a), .b(w_b), .busy(w_busy), .ack(w_ack),
    .done(w_done), .aborted(w_abt),
    .enter_count(w_ec), .exit_count(w_xc)
  );

  task automatic check(string name, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // o = {a, b, busy, ack, done, aborted} after the edge
  typedef struct {
    bit       en;
    bit       ex;
    bit       ab;
    bit [7:0] dw;
    bit [5:0] o;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(bit en, bit ex, bit ab,
                            int dw, bit [5:0] o);
    vec_t t;
    t.en = en;
    t.ex = ex;
    t.ab = ab;
    t.dw = dw[7:0];
    t.o  = o;
    tbl.push_back(t);
  endfunction

  function automatic void rep(int n, bit [5:0] o);
    for (int i = 0; i < n; i++) v(0, 0, 0, 0, o);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit [1:0] ab;
    bit       busy;
    bit       ack;
    bit       done;
    bit       abt;
    int       ph;
    int       ev;
  } ex_t;

  ex_t q[$];
  ex_t cur;
  bit  m_dir;
  int  m_d;
  int  m_en;
  int  m_ex;

  // phase p of the car path: 1..3 beams, 0 = clear
  function automatic bit [1:0] phase_ab(bit dir, int p);
    bit [1:0] e;
    case (p)
      1:       e = 2'b10;
      2:       e = 2'b11;
      3:       e = 2'b01;
      default: e = 2'b00;
    endcase
    return dir ? {e[0], e[1]} : e;
  endfunction

  function automatic void qpush(bit [1:0] ab, bit bz,
                                bit ak, bit dn, bit abt,
                                int ph, int ev);
    ex_t e;
    e.ab = ab;
    e.busy = bz;
    e.ack = ak;
    e.done = dn;
    e.abt = abt;
    e.ph = ph;
    e.ev = ev;
    q.push_back(e);
  endfunction

  function automatic void m_reset();
    q.delete();
    qpush(2'b00, 0, 0, 0, 0, 0, 0);
    cur = q.pop_front();
    m_en = 0;
    m_ex = 0;
    m_dir = 0;
    m_d = 1;
  endfunction

  task automatic m_step(bit en, bit ex, bit ab,
                        bit [7:0] dw);
    int p;
    if (!cur.busy) begin
      q.delete();
      if (en || ex) begin
        m_dir = !en;
        m_d = (dw == 0) ? 1 : int'(dw);
        for (int s = 1; s <= 4; s++)
          for (int k = 0; k < m_d; k++)
            qpush(phase_ab(m_dir, s % 4), 1,
                  (s == 1 && k == 0), 0, 0,
                  s % 4, 0);
        qpush(2'b00, 0, 0, 1, 0, 0, m_dir ? 2 : 1);
      end else begin
        qpush(2'b00, 0, 0, 0, 0, 0, 0);
      end
    end else if (cur.ph != 0 && ab) begin
      // reverse along the path already travelled
      p = cur.ph;
      q.delete();
      for (int s = p - 1; s >= 0; s--)
        for (int k = 0; k < m_d; k++)
          qpush(phase_ab(m_dir, s), 1, 0, 0, 0, 0, 0);
      qpush(2'b00, 0, 0, 0, 1, 0, 0);
    end
    cur = q.pop_front();
    if (cur.ev == 1) m_en++;
    if (cur.ev == 2) m_ex++;
  endtask

  initial begin
    logic [37:0] got;
    logic [37:0] exp;
    bit          r_en, r_ex, r_ab;
    bit [7:0]    r_dw;

    reset_n = 1'b0;
    enter_req = 1'b0;
    exit_req = 1'b0;
    abort = 1'b0;
    dwell_cycles = 8'd0;
    w_en = 1'b0;

    // T1 dwell 3 enter
    v(1, 0, 0, 3, 6'b101100);
    rep(2, 6'b101000);
    rep(3, 6'b111000);
    rep(3, 6'b011000);
    rep(3, 6'b001000);
    rep(1, 6'b000010);
    // T2 dwell 0 exit
    v(0, 1, 0, 0, 6'b011100);
    rep(1, 6'b111000);
    rep(1, 6'b101000);
    rep(1, 6'b001000);
    rep(1, 6'b000010);
    // T3 both high, enter dropped after ack
    v(1, 1, 0, 0, 6'b101100);
    v(0, 1, 0, 0, 6'b111000);
    v(0, 1, 0, 0, 6'b011000);
    v(0, 1, 0, 0, 6'b001000);
    v(0, 1, 0, 0, 6'b000010);
    v(0, 1, 0, 0, 6'b011100);
    rep(1, 6'b111000);
    rep(1, 6'b101000);
    rep(1, 6'b001000);
    rep(1, 6'b000010);
    // T4 dwell 2, abort in 2nd cycle of P3
    v(1, 0, 0, 2, 6'b101100);
    rep(1, 6'b101000);
    rep(2, 6'b111000);
    rep(2, 6'b011000);
    v(0, 0, 1, 0, 6'b111000);
    rep(1, 6'b111000);
    rep(2, 6'b101000);
    rep(2, 6'b001000);
    rep(1, 6'b000001);
    // abort in P1 goes straight to clear
    v(1, 0, 0, 1, 6'b101100);
    v(0, 0, 1, 0, 6'b001000);
    rep(1, 6'b000001);

    repeat (2) @(negedge clk);
    check("reset_state",
          {a, b, busy, ack, done, aborted,
           enter_count, exit_count}, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      enter_req = tbl[i].en;
      exit_req = tbl[i].ex;
      abort = tbl[i].ab;
      dwell_cycles = tbl[i].dw;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {a, b, busy, ack, done, aborted}, tbl[i].o);
    end
    enter_req = 1'b0;
    exit_req = 1'b0;
    abort = 1'b0;
    check("tbl_enter_count", enter_count, 2);
    check("tbl_exit_count", exit_count, 2);

    // T5 async reset during P2
    enter_req = 1'b1;
    dwell_cycles = 8'd2;
    @(negedge clk);
    enter_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_in_p2", {a, b, busy}, 3'b111);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_out",
          {a, b, busy, ack, done, aborted}, 0);
    check("t5_counts", {enter_count, exit_count}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_idle",
            {a, b, busy, ack, done, aborted}, 0);
    end

    // random traffic against the model
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      r_en = ($urandom % 7) == 0;
      r_ex = ($urandom % 7) == 0;
      r_ab = ($urandom % 12) == 0;
      r_dw = 8'($urandom % 4);
      enter_req = r_en;
      exit_req = r_ex;
      abort = r_ab;
      dwell_cycles = r_dw;
      @(posedge clk);
      m_step(r_en, r_ex, r_ab, r_dw);
      @(negedge clk);
      got = {a, b, busy, ack, done, aborted,
             enter_count, exit_count};
      exp = {cur.ab, cur.busy, cur.ack, cur.done,
             cur.abt, m_en[15:0], m_ex[15:0]};
      check($sformatf("rand%0d", i), got, exp);
    end
    enter_req = 1'b0;
    exit_req = 1'b0;
    abort = 1'b0;

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1;
      @(negedge clk);
      w_en = 1'b0;
      repeat (5) @(negedge clk);
      check("wrap_count", w_ec, (i + 1) % 16);
    end
    check("wrap_exit", w_xc, 0);
    check("wrap_idle",
          {w_a, w_b, w_busy, w_ack, w_done, w_abt}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
